// File: rtl/eth_tx_sched_if.sv
// Frame-source / transmitter bundle around the eth_tx_sched frame scheduler.
// The frame sources and the RGMII transmitter sit on the master side, and the
// scheduler sits on the slave side.
interface eth_tx_sched_if;
  logic [1:0]  req;
  logic [10:0] len0;
  logic [10:0] len1;
  logic [1:0]  gnt;
  logic [1:0]  err;
  logic [1:0]  rd;
  logic [7:0]  data0;
  logic [7:0]  data1;
  logic        out_en;
  logic [7:0]  out_data;
  logic        busy;
  logic [15:0] frame_cnt;

  modport master (
    output req, len0, len1, data0, data1,
    input  gnt, err, rd, out_en, out_data, busy, frame_cnt
  );

  modport slave (
    input  req, len0, len1, data0, data1,
    output gnt, err, rd, out_en, out_data, busy, frame_cnt
  );
endinterface

// File: rtl/eth_tx_sched.sv
// Round-robin frame scheduler in the clk125 byte domain. It picks one of two
// byte-stream sources, then emits preamble, SFD and the payload bytes, and
// finally holds the line idle for the inter-frame gap. Every output is
// registered. Source bytes are fetched one cycle ahead with rd so that the
// registered out_data can carry them without a bubble.
module eth_tx_sched #(
  parameter int IFG_BYTES = 12,
  parameter int MAX_LEN   = 1514,
  parameter int PRE_BYTES = 7
) (
  input  logic           clk125,
  input  logic           rst,
  eth_tx_sched_if.slave  tx_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_IFG
  } state_t;

  localparam logic [7:0]  PRE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE  = 8'hD5;
  localparam logic [3:0]  PRE_LAST  = 4'(PRE_BYTES - 1);
  localparam logic [7:0]  IFG_LAST  = 8'(IFG_BYTES - 1);
  localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);

  state_t      state_q;
  logic        last_q;      // source granted or rejected most recently
  logic        src_q;       // source owning the frame in flight
  logic [10:0] cnt_q;       // payload bytes still to be shown on out_data
  logic [3:0]  pre_q;       // preamble bytes left after the current one
  logic [7:0]  ifg_q;       // gap cycles left after the current one
  logic [1:0]  gnt_q;
  logic [1:0]  err_q;
  logic [1:0]  rd_q;
  logic        out_en_q;
  logic [7:0]  out_data_q;
  logic        busy_q;
  logic [15:0] frame_cnt_q;

  logic [1:0]  req_d;
  logic        win_d;
  logic [10:0] len_d;
  logic        len_ok_d;
  logic [7:0]  byte_d;

  // Map a source index onto its one-hot strobe position.
  function automatic logic [1:0] onehot(input logic src);
    return src ? 2'b10 : 2'b01;
  endfunction

  // Arbitration for the IDLE decision: a source that was just rejected is
  // still dropping its request this cycle, so it is not considered again.
  always_comb begin
    req_d    = tx_if.req & ~err_q;
    win_d    = 1'b0;
    if (req_d == 2'b11) begin
      win_d = ~last_q;
    end else if (req_d == 2'b10) begin
      win_d = 1'b1;
    end
    len_d    = win_d ? tx_if.len1 : tx_if.len0;
    len_ok_d = (len_d != 11'd0) && (len_d <= MAX_LEN_W);
  end

  // Byte presented by the source that owns the current frame.
  always_comb begin
    byte_d = src_q ? tx_if.data1 : tx_if.data0;
  end

  // Frame sequencer: IDLE -> PRE -> SFD -> DATA -> IFG -> IDLE, with all
  // outputs updated alongside the state.
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      src_q       <= 1'b0;
      cnt_q       <= 11'd0;
      pre_q       <= 4'd0;
      ifg_q       <= 8'd0;
      gnt_q       <= 2'b00;
      err_q       <= 2'b00;
      rd_q        <= 2'b00;
      out_en_q    <= 1'b0;
      out_data_q  <= 8'h00;
      busy_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      gnt_q <= 2'b00;
      err_q <= 2'b00;
      rd_q  <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (req_d != 2'b00) begin
            last_q <= win_d;
            if (len_ok_d) begin
              gnt_q      <= onehot(win_d);
              src_q      <= win_d;
              cnt_q      <= len_d;
              pre_q      <= PRE_LAST;
              out_en_q   <= 1'b1;
              out_data_q <= PRE_BYTE;
              busy_q     <= 1'b1;
              state_q    <= S_PRE;
            end else begin
              err_q <= onehot(win_d);
            end
          end
        end
        S_PRE: begin
          if (pre_q == 4'd0) begin
            out_data_q <= SFD_BYTE;
            rd_q       <= onehot(src_q);
            state_q    <= S_SFD;
          end else begin
            pre_q <= pre_q - 4'd1;
          end
        end
        S_SFD: begin
          // First payload byte was fetched during SFD; fetch the next one
          // only when the frame has more than one byte.
          out_data_q <= byte_d;
          rd_q       <= (cnt_q > 11'd1) ? onehot(src_q) : 2'b00;
          state_q    <= S_DATA;
        end
        S_DATA: begin
          if (cnt_q == 11'd1) begin
            out_en_q    <= 1'b0;
            out_data_q  <= 8'h00;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            ifg_q       <= IFG_LAST;
            state_q     <= S_IFG;
          end else begin
            // The byte shown next was read in this cycle; no read is issued
            // for the cycle that shows the final byte.
            cnt_q      <= cnt_q - 11'd1;
            out_data_q <= byte_d;
            rd_q       <= (cnt_q > 11'd2) ? onehot(src_q) : 2'b00;
          end
        end
        S_IFG: begin
          if (ifg_q == 8'd0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            ifg_q <= ifg_q - 8'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_if.gnt       = gnt_q;
  assign tx_if.err       = err_q;
  assign tx_if.rd        = rd_q;
  assign tx_if.out_en    = out_en_q;
  assign tx_if.out_data  = out_data_q;
  assign tx_if.busy      = busy_q;
  assign tx_if.frame_cnt = frame_cnt_q;

  // Strobes are one-hot at most, and bytes only flow while a frame is active.
  a_gnt_onehot : assert property (@(posedge clk125) disable iff (rst) $onehot0(gnt_q));
  a_err_onehot : assert property (@(posedge clk125) disable iff (rst) $onehot0(err_q));
  a_rd_onehot  : assert property (@(posedge clk125) disable iff (rst) $onehot0(rd_q));
  a_en_busy    : assert property (@(posedge clk125) disable iff (rst) out_en_q |-> busy_q);

endmodule
